ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 148 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_stage
// Purpose : EX->MEM pipeline register with exception detection and byte enables
// Revision: 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
  parameter logic [4:0] EXC_OV   = 5'h0C,
  parameter logic [4:0] EXC_ADEL = 5'h04,
  parameter logic [4:0] EXC_ADES = 5'h05
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_res,
  input  logic        ex_alu_ov,
  input  logic        ex_ov_trap,
  input  logic [4:0]  ex_dest,
  input  logic        ex_wen,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [1:0]  ex_mem_size,
  input  logic [31:0] ex_store_data,
  input  logic        flush,
  input  logic        mem_ready,
  output logic        mem_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_alu_res,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_dest,
  output logic        mem_wen,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_alu_res;
  logic [31:0] r_store_data;
  logic [4:0]  r_dest;
  logic        r_wen;
  logic        r_rd;
  logic        r_wr;
  logic [1:0]  r_size;
  logic        r_exc;
  logic [4:0]  r_exc_code;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_exc;
  logic [4:0]  w_exc_code;
  logic [3:0]  w_be;

  assign ex_ready = !r_valid || mem_ready;
  assign w_accept = ex_valid && ex_ready;

  // Size 3 is handled as a word access.
  always_comb begin
    w_misaligned = 1'b0;
    case (ex_mem_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = ex_alu_res[0];
      default: w_misaligned = (ex_alu_res[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    w_exc      = 1'b1;
    w_exc_code = 5'h00;
    if (ex_ov_trap && ex_alu_ov) begin
      w_exc_code = EXC_OV;
    end else if (ex_mem_rd && w_misaligned) begin
      w_exc_code = EXC_ADEL;
    end else if (ex_mem_wr && w_misaligned) begin
      w_exc_code = EXC_ADES;
    end else begin
      w_exc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_pc         <= 32'h0;
      r_alu_res    <= 32'h0;
      r_store_data <= 32'h0;
      r_dest       <= 5'h0;
      r_wen        <= 1'b0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_size       <= 2'd0;
      r_exc        <= 1'b0;
      r_exc_code   <= 5'h0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (mem_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_pc         <= ex_pc;
        r_alu_res    <= ex_alu_res;
        r_store_data <= ex_store_data;
        r_dest       <= ex_dest;
        r_wen        <= ex_wen;
        r_rd         <= ex_mem_rd;
        r_wr         <= ex_mem_wr;
        r_size       <= ex_mem_size;
        r_exc        <= w_exc;
        r_exc_code   <= w_exc_code;
      end
    end
  end

  always_comb begin
    w_be = 4'b0000;
    if ((r_rd || r_wr) && !r_exc) begin
      case (r_size)
        2'd0:    w_be = 4'b0001 << r_alu_res[1:0];
        2'd1:    w_be = r_alu_res[1] ? 4'b1100 : 4'b0011;
        default: w_be = 4'b1111;
      endcase
    end
  end

  assign mem_valid      = r_valid;
  assign mem_pc         = r_pc;
  assign mem_alu_res    = r_alu_res;
  assign mem_store_data = r_store_data;
  assign mem_dest       = r_dest;
  assign mem_wen        = r_wen && !r_exc && (r_dest != 5'h0);
  assign mem_rd         = r_rd && !r_exc;
  assign mem_wr         = r_wr && !r_exc;
  assign mem_be         = w_be;
  assign exc_valid      = r_valid && r_exc;
  assign exc_code       = r_exc_code;
  assign exc_epc        = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_mem_stage
// Purpose : directed + random checks of ex_mem_stage against a reference model
// Revision: 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_alu_res, ex_store_data;
  logic        ex_alu_ov, ex_ov_trap, ex_wen, ex_mem_rd, ex_mem_wr;
  logic [4:0]  ex_dest;
  logic [1:0]  ex_mem_size;
  logic        flush, mem_ready;
  logic        mem_valid, mem_wen, mem_rd, mem_wr, exc_valid;
  logic [31:0] mem_pc, mem_alu_res, mem_store_data, exc_epc;
  logic [4:0]  mem_dest, exc_code;
  logic [3:0]  mem_be;

  int checks   = 0;
  int failures = 0;

  // Reference model: the architectural content of the held slot.
  bit        m_valid;
  bit [31:0] m_pc, m_alu, m_sd;
  bit [4:0]  m_dest, m_code;
  bit        m_wen, m_rd, m_wr, m_exc;
  bit [1:0]  m_size;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_alu_res(ex_alu_res), .ex_alu_ov(ex_alu_ov),
    .ex_ov_trap(ex_ov_trap), .ex_dest(ex_dest), .ex_wen(ex_wen),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_mem_size(ex_mem_size),
    .ex_store_data(ex_store_data), .flush(flush), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_res(mem_alu_res),
    .mem_store_data(mem_store_data), .mem_dest(mem_dest), .mem_wen(mem_wen),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_be(mem_be), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_epc(exc_epc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_pc = 0; m_alu = 0; m_sd = 0; m_dest = 0; m_code = 0;
    m_wen = 0; m_rd = 0; m_wr = 0; m_exc = 0; m_size = 0;
  endtask

  task automatic check_all();
    bit [3:0] be;
    int off;
    off = int'(m_alu % 4);
    if (!(m_rd || m_wr) || m_exc) be = 4'h0;
    else if (m_size == 0)         be = 4'(1 << off);
    else if (m_size == 1)         be = (off >= 2) ? 4'hC : 4'h3;
    else                          be = 4'hF;
    chk("mem_valid", 32'(mem_valid), 32'(m_valid));
    chk("mem_pc", mem_pc, m_pc);
    chk("mem_alu_res", mem_alu_res, m_alu);
    chk("mem_store_data", mem_store_data, m_sd);
    chk("mem_dest", 32'(mem_dest), 32'(m_dest));
    chk("mem_wen", 32'(mem_wen), 32'(m_wen && !m_exc && m_dest != 0));
    chk("mem_rd", 32'(mem_rd), 32'(m_rd && !m_exc));
    chk("mem_wr", 32'(mem_wr), 32'(m_wr && !m_exc));
    chk("mem_be", 32'(mem_be), 32'(be));
    chk("exc_valid", 32'(exc_valid), 32'(m_valid && m_exc));
    chk("exc_code", 32'(exc_code), 32'(m_code));
    chk("exc_epc", exc_epc, m_pc);
  endtask

  // Inputs are set ~1 time unit after a rising edge; this advances one cycle.
  task automatic cycle();
    bit acc, mis;
    #1;
    chk("ex_ready", 32'(ex_ready), 32'(!m_valid || mem_ready));
    acc = ex_valid && (!m_valid || mem_ready);
    if (acc) begin
      if (ex_mem_size == 0)      mis = 0;
      else if (ex_mem_size == 1) mis = (ex_alu_res % 2) != 0;
      else                       mis = (ex_alu_res % 4) != 0;
      m_pc = ex_pc; m_alu = ex_alu_res; m_sd = ex_store_data; m_dest = ex_dest;
      m_wen = ex_wen; m_rd = ex_mem_rd; m_wr = ex_mem_wr; m_size = ex_mem_size;
      m_exc = 1;
      if (ex_ov_trap && ex_alu_ov)  m_code = 5'h0C;
      else if (ex_mem_rd && mis)    m_code = 5'h04;
      else if (ex_mem_wr && mis)    m_code = 5'h05;
      else begin m_code = 0; m_exc = 0; end
    end
    if (flush)          m_valid = 0;
    else if (acc)       m_valid = 1;
    else if (mem_ready) m_valid = 0;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_op(input bit [31:0] pc, input bit [31:0] addr, input bit rd,
                        input bit wr, input bit [1:0] size, input bit [4:0] dest, input bit wen);
    ex_valid = 1; ex_pc = pc; ex_alu_res = addr; ex_mem_rd = rd; ex_mem_wr = wr;
    ex_mem_size = size; ex_dest = dest; ex_wen = wen; ex_alu_ov = 0; ex_ov_trap = 0;
    ex_store_data = $urandom;
  endtask

  initial begin
    reset = 0; ex_valid = 0; ex_pc = 0; ex_alu_res = 0; ex_store_data = 0;
    ex_alu_ov = 0; ex_ov_trap = 0; ex_wen = 0; ex_mem_rd = 0; ex_mem_wr = 0;
    ex_dest = 0; ex_mem_size = 0; flush = 0; mem_ready = 1;
    model_clear();
    #3;
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_exc_valid", 32'(exc_valid), 32'h0);
    chk("rst_ex_ready", 32'(ex_ready), 32'h1);
    @(posedge clk); #1;
    check_all();
    reset = 1;
    @(posedge clk); #1;

    // Overflow trap on add.
    set_op(32'hBFC00010, 32'h80000000, 0, 0, 2'd2, 5'd5, 1);
    ex_alu_ov = 1; ex_ov_trap = 1;
    cycle();
    chk("ov_exc_valid", 32'(exc_valid), 32'h1);
    chk("ov_exc_code", 32'(exc_code), 32'h0C);

    // Misaligned halfword load.
    set_op(32'h00400000, 32'h00000103, 1, 0, 2'd1, 5'd3, 1);
    cycle();
    chk("adel_code", 32'(exc_code), 32'h04);

    // Aligned byte store.
    set_op(32'h00400004, 32'h00000102, 0, 1, 2'd0, 5'd0, 0);
    cycle();
    chk("sb_be", 32'(mem_be), 32'h4);

    // Misaligned word store, overflow flag present but not trapping.
    set_op(32'h00400008, 32'h00000202, 0, 1, 2'd3, 5'd0, 0);
    ex_alu_ov = 1;
    cycle();
    chk("ades_code", 32'(exc_code), 32'h05);

    // Stall for three cycles with a new instruction waiting, then swap.
    set_op(32'h00400010, 32'h00000200, 0, 1, 2'd2, 5'd0, 0);
    cycle();
    mem_ready = 0;
    set_op(32'h00400014, 32'h00000300, 1, 0, 2'd2, 5'd7, 1);
    repeat (3) cycle();
    chk("stall_pc", mem_pc, 32'h00400010);
    mem_ready = 1;
    cycle();
    chk("swap_pc", mem_pc, 32'h00400014);

    // Flush coinciding with an accept.
    set_op(32'h00400018, 32'h00000004, 1, 0, 2'd2, 5'd9, 1);
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_valid", 32'(mem_valid), 32'h0);

    // Reset pulse mid-stall drops the held entry without a clock edge.
    set_op(32'h0040001C, 32'h00000008, 0, 1, 2'd2, 5'd0, 0);
    cycle();
    mem_ready = 0;
    cycle();
    #2;
    reset = 0;
    #1;
    model_clear();
    chk("rstmid_mem_valid", 32'(mem_valid), 32'h0);
    chk("rstmid_mem_be", 32'(mem_be), 32'h0);
    chk("rstmid_exc_valid", 32'(exc_valid), 32'h0);
    chk("rstmid_ex_ready", 32'(ex_ready), 32'h1);
    #1;
    reset = 1;
    mem_ready = 1;
    set_op(32'h00400020, 32'h00000011, 1, 0, 2'd0, 5'd4, 1);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      ex_valid      = ($urandom_range(0, 3) != 0);
      mem_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      ex_pc         = $urandom;
      ex_alu_res    = $urandom;
      ex_store_data = $urandom;
      ex_alu_ov     = ($urandom_range(0, 3) == 0);
      ex_ov_trap    = ($urandom_range(0, 1) == 1);
      ex_dest       = 5'($urandom_range(0, 31));
      ex_wen        = ($urandom_range(0, 1) == 1);
      ex_mem_rd     = (kind == 1);
      ex_mem_wr     = (kind == 2);
      ex_mem_size   = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
